dec_serializer: RTL
===================

DEC_SERIALIZER -- requirements
Module: dec_serializer

Interface
REQ-001 Parameter DATA_W, default 22: width of the decimated input word.
REQ-002 Parameter CLK_DIV, default 4: serial bit period in clk_fs cycles; even, >= 2.
REQ-003 Port clk_fs, input, 1: sole clock; all state on its rising edge.
REQ-004 Port rst_b, input, 1: reset, asynchronous, active-low.
REQ-005 Port data_in, input, DATA_W: signed decimator output word.
REQ-006 Port valid_in, input, 1: single-cycle strobe qualifying data_in; driven by decimator valid_strobe.
REQ-007 Port overrun_clr, input, 1: synchronous clear of overrun.
REQ-008 Port ser_clk, output, 1: serial clock, a registered output.
REQ-009 Port ser_data, output, 1: serial data, MSB first, a registered output.
REQ-010 Port ser_frame, output, 1: high for every bit period of a frame, a registered output.
REQ-011 Port overrun, output, 1: sticky word-drop flag.
REQ-012 Port busy, output, 1: high when the FSM is not IDLE or the FIFO is not empty.

Function
REQ-013 A 2-entry FIFO SHALL buffer words; the FIFO SHALL write data_in on every clk_fs edge where valid_in=1 and the FIFO is not full.
REQ-014 If valid_in=1 while the FIFO is full and no pop occurs that cycle, the word SHALL be dropped, FIFO contents SHALL be unchanged, and overrun SHALL be set to 1.
REQ-015 A simultaneous pop and valid_in on a full FIFO SHALL accept the write with no overrun.
REQ-016 overrun SHALL stay 1 until an edge with overrun_clr=1; if set and clear coincide, set SHALL win.
REQ-017 FSM states: IDLE, SHIFT, GAP.
REQ-018 IDLE with FIFO non-empty: the FSM SHALL pop the head into a shift register of DATA_W+1 bits ({word, even parity}) and enter SHIFT.
REQ-019 Parity bit = XOR of all DATA_W word bits, so the count of ones over the DATA_W+1 bits is even.
REQ-020 SHIFT SHALL last exactly (DATA_W+1)*CLK_DIV cycles.
REQ-021 In SHIFT, ser_frame SHALL be 1.
REQ-022 In SHIFT, each bit SHALL be held on ser_data for CLK_DIV cycles.
REQ-023 In SHIFT, ser_clk SHALL be 0 for the first CLK_DIV/2 cycles of each bit period and 1 for the remainder; ser_data changes only at the start of a bit period, when ser_clk goes low.
REQ-024 GAP SHALL last CLK_DIV cycles with ser_frame=0, ser_clk=0 and ser_data=0, then go to IDLE.
REQ-025 Latency: valid_in sampled high at edge E with IDLE and FIFO empty -> the first bit (MSB) and ser_frame=1 SHALL appear at the outputs after edge E+2.
REQ-026 Frame pitch (DATA_W+2)*CLK_DIV = 96 cycles at defaults SHALL be less than 256, so a steady decimator stream never overruns.
REQ-027 Outside SHIFT: ser_clk=0, ser_data=0, ser_frame=0.

Reset
REQ-028 rst_b low SHALL immediately force FSM=IDLE, FIFO empty, counters=0, shift register=0, ser_clk=0, ser_data=0, ser_frame=0, overrun=0 and busy=0, including mid-frame.
REQ-029 After rst_b deasserts, the first frame SHALL start only from a valid_in received after reset; an aborted word SHALL never be resent.

Structure
REQ-030 A shared package dec_ser_pkg SHALL hold the DATA_W and CLK_DIV defaults and the FSM state encoding.
REQ-031 The FIFO SHALL be the sub-module dec_ser_fifo (depth 2, DATA_W wide, with full/empty flags and push/pop).
REQ-032 The block SHALL contain no other hierarchy, and there SHALL be no combinational path from inputs to ser_* outputs.

Verification
REQ-033 Scenario (CLK_DIV=4): data_in=0x2AAAAA pulse -> ser_data bits 1,0,1,0,...,0, then parity 1; 92 cycles ser_frame=1, MSB after E+2.
REQ-034 Scenario: 0x200000 -> bit stream 1 followed by 21 zeros, parity 1; 0x000000 -> 23 zeros with ser_frame high for 92 cycles.
REQ-035 Scenario: 4 valid_in on consecutive cycles (words A,B,C,D) -> frames A,B,C serialized back-to-back with a 4-cycle gap; D dropped; overrun=1 until overrun_clr.
REQ-036 Scenario: rst_b low at cycle 30 of a frame -> all outputs 0 asynchronously; no frame after release until a new valid_in.
REQ-037 Scenario: chain with decimator_top, valid strobe every 256 cycles for 100 words -> 100 frames, each word matching its decoded data_out and parity, overrun=0.
REQ-038 Scenario: overrun_clr coinciding with a drop -> overrun remains 1.

Source files
------------

// File: rtl/dec_ser_pkg.sv
// ============================================================
// Module  : dec_ser_pkg
// Brief   : Shared defaults and FSM encoding for dec_serializer
// Revision: 1.0
// ============================================================
`default_nettype none

package dec_ser_pkg;

  localparam int c_DATA_W  = 22;
  localparam int c_CLK_DIV = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } dec_ser_state_t;

endpackage

`default_nettype wire

// File: rtl/dec_ser_fifo.sv
// ============================================================
// Module  : dec_ser_fifo
// Brief   : Two-entry word FIFO with push/pop and full/empty flags
// Revision: 1.0
// ============================================================
`default_nettype none

module dec_ser_fifo
  import dec_ser_pkg::*;
#(
  parameter int DATA_W = c_DATA_W
) (
  input  logic              clk_fs,
  input  logic              rst_b,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == 2'd2);
  assign o_empty   = (r_count == 2'd0);
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees the head slot this edge, so a full FIFO can still take a push.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk_fs or negedge rst_b) begin
    if (!rst_b) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/dec_serializer.sv
// ============================================================
// Module  : dec_serializer
// Brief   : Buffers decimator words and shifts them out MSB first with even parity
// Revision: 1.0
// ============================================================
`default_nettype none

module dec_serializer
  import dec_ser_pkg::*;
#(
  parameter int DATA_W  = c_DATA_W,
  parameter int CLK_DIV = c_CLK_DIV
) (
  input  logic              clk_fs,
  input  logic              rst_b,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              overrun_clr,
  output logic              ser_clk,
  output logic              ser_data,
  output logic              ser_frame,
  output logic              overrun,
  output logic              busy
);

  localparam int c_PH_W  = $clog2(CLK_DIV);
  localparam int c_BIT_W = $clog2(DATA_W + 1);
  localparam logic [c_PH_W-1:0]  c_PH_LAST  = c_PH_W'(CLK_DIV - 1);
  localparam logic [c_PH_W-1:0]  c_PH_HALF  = c_PH_W'(CLK_DIV / 2);
  localparam logic [c_PH_W-1:0]  c_PH_ONE   = c_PH_W'(1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(DATA_W);
  localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);

  dec_ser_state_t     r_state;
  dec_ser_state_t     w_state_nxt;
  logic [c_PH_W-1:0]  r_phase;
  logic [c_BIT_W-1:0] r_bit;
  logic [DATA_W:0]    r_shreg;
  logic               r_ser_clk;
  logic               r_ser_data;
  logic               r_ser_frame;
  logic               r_overrun;

  logic [DATA_W-1:0]  w_fifo_rdata;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_bit_end;
  logic               w_load;
  logic               w_drop;

  dec_ser_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_fs  (clk_fs),
    .rst_b   (rst_b),
    .i_push  (valid_in),
    .i_pop   (w_load),
    .i_wdata (data_in),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_bit_end = (r_phase == c_PH_LAST);
  // The last gap cycle doubles as the IDLE decision, keeping the frame pitch at (DATA_W+2)*CLK_DIV.
  assign w_load    = ((r_state == ST_IDLE) || ((r_state == ST_GAP) && w_bit_end)) && !w_fifo_empty;
  assign w_drop    = valid_in && w_fifo_full && !w_load;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_load) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_bit_end && (r_bit == c_BIT_LAST)) w_state_nxt = ST_GAP;
      ST_GAP:   if (w_bit_end) w_state_nxt = w_load ? ST_SHIFT : ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_fs or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_fs or negedge rst_b) begin
    if (!rst_b) begin
      r_phase <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
    end else if (w_load) begin
      r_shreg <= {w_fifo_rdata, ^w_fifo_rdata};
      r_phase <= '0;
      r_bit   <= '0;
    end else if (r_state != ST_IDLE) begin
      r_phase <= w_bit_end ? '0 : r_phase + c_PH_ONE;
      if ((r_state == ST_SHIFT) && w_bit_end) begin
        r_shreg <= {r_shreg[DATA_W-1:0], 1'b0};
        r_bit   <= r_bit + c_BIT_ONE;
      end
    end
  end

  // Serial outputs are registered from the current state, one cycle behind the shifter.
  always_ff @(posedge clk_fs or negedge rst_b) begin
    if (!rst_b) begin
      r_ser_frame <= 1'b0;
      r_ser_clk   <= 1'b0;
      r_ser_data  <= 1'b0;
    end else begin
      r_ser_frame <= (r_state == ST_SHIFT);
      r_ser_clk   <= (r_state == ST_SHIFT) && (r_phase >= c_PH_HALF);
      r_ser_data  <= (r_state == ST_SHIFT) && r_shreg[DATA_W];
    end
  end

  always_ff @(posedge clk_fs or negedge rst_b) begin
    if (!rst_b) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

  assign ser_clk   = r_ser_clk;
  assign ser_data  = r_ser_data;
  assign ser_frame = r_ser_frame;
  assign overrun   = r_overrun;
  assign busy      = (r_state != ST_IDLE) || !w_fifo_empty;

endmodule

`default_nettype wire
